// File: rtl/riscv_pkg.sv
// Shared definitions for the retire-stage observation logic:
// opcode constants, halt-sequence words and the halt FSM state type.
package riscv_pkg;

   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;

   // addi x1,x0,12 followed by jalr x0,0(x1) ends a test program
   localparam logic [31:0] HALT_WORD0 = 32'h00c00093;
   localparam logic [31:0] HALT_WORD1 = 32'h00008067;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      HALTED = 2'd2
   } halt_state_e;

endpackage

// File: rtl/riscv_halt_detect.sv
// Halt-sequence detector: watches accepted retires for HALT_INST0 followed
// (bubbles allowed in between) by HALT_INST1. HALTED is absorbing until reset.
module riscv_halt_detect
   import riscv_pkg::*;
#(
   parameter logic [31:0] HALT_INST0 = HALT_WORD0,
   parameter logic [31:0] HALT_INST1 = HALT_WORD1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        valid_i,
   input  logic [31:0] inst_i,
   output logic        halted_o
);

   halt_state_e state_q;
   logic        halted_q;

   // Sequence FSM with registered halted flag, advanced only on valid retires
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         halted_q <= 1'b0;
      end else if (valid_i) begin
         case (state_q)
            IDLE: begin
               if (inst_i == HALT_INST0) state_q <= ARMED;
            end
            ARMED: begin
               if (inst_i == HALT_INST1) begin
                  state_q  <= HALTED;
                  halted_q <= 1'b1;
               end else if (inst_i == HALT_INST0) begin
                  state_q <= ARMED;
               end else begin
                  state_q <= IDLE;
               end
            end
            HALTED: begin
               state_q  <= HALTED;
               halted_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign halted_o = halted_q;

endmodule

// File: rtl/riscv_retire_monitor.sv
// Retire-stage observation producer: retired-instruction counter, per-retire
// OUTPUT_PORT value and sticky HALT flag. All outputs are registered.
// Optional macro RETIRE_CYCLE_CNT_EN adds CYCLE_CNT, a cycle counter that
// runs until HALT rises.
module riscv_retire_monitor
   import riscv_pkg::*;
#(
   parameter logic [31:0] HALT_INST0 = HALT_WORD0,
   parameter logic [31:0] HALT_INST1 = HALT_WORD1,
   parameter int          CNT_WIDTH  = 32
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 RETIRE_VALID,
   input  logic [31:0]          RETIRE_INST,
   input  logic                 RETIRE_RF_WE,
   input  logic [4:0]           RETIRE_RF_WA,
   input  logic [31:0]          RETIRE_RF_WD,
   input  logic [11:0]          RETIRE_MEM_ADDR,
   input  logic                 RETIRE_BR_TAKEN,
   output logic [CNT_WIDTH-1:0] NUM_INST,
   output logic [31:0]          OUTPUT_PORT,
   output logic                 HALT
`ifdef RETIRE_CYCLE_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] CYCLE_CNT
`endif
);

   logic                 halted;
   logic                 accept;
   logic [CNT_WIDTH-1:0] num_q, num_d;
   logic [31:0]          out_q, out_d;

   // Once halted, retires no longer touch any architectural observation state
   assign accept = RETIRE_VALID & ~halted;

   riscv_halt_detect #(
      .HALT_INST0 (HALT_INST0),
      .HALT_INST1 (HALT_INST1)
   ) u_halt (
      .clk_i    (CLK),
      .rst_i    (RST),
      .valid_i  (accept),
      .inst_i   (RETIRE_INST),
      .halted_o (halted)
   );

   // Next-state for the counter and the opcode-selected observation value
   always_comb begin
      num_d = num_q;
      out_d = out_q;
      if (accept) begin
         num_d = num_q + 1'b1;
         case (RETIRE_INST[6:0])
            OP_STORE:  out_d = {20'b0, RETIRE_MEM_ADDR};
            OP_BRANCH: out_d = {31'b0, RETIRE_BR_TAKEN};
            default: begin
               if (RETIRE_RF_WE && (RETIRE_RF_WA != 5'd0)) out_d = RETIRE_RF_WD;
            end
         endcase
      end
   end

   // Counter and observation registers, reset dominates
   always_ff @(posedge CLK) begin
      if (RST) begin
         num_q <= '0;
         out_q <= '0;
      end else begin
         num_q <= num_d;
         out_q <= out_d;
      end
   end

   assign NUM_INST    = num_q;
   assign OUTPUT_PORT = out_q;
   assign HALT        = halted;

`ifdef RETIRE_CYCLE_CNT_EN
   logic [CNT_WIDTH-1:0] cyc_q;

   // Free-running cycle count that stops on the edge after HALT rises
   always_ff @(posedge CLK) begin
      if (RST)          cyc_q <= '0;
      else if (!halted) cyc_q <= cyc_q + 1'b1;
   end

   assign CYCLE_CNT = cyc_q;
`endif

endmodule

// File: tb/tb_riscv_retire_monitor.sv
// Directed bench for riscv_retire_monitor: reset, output mux, halt sequence,
// reset mid-sequence and counter wrap (via a narrow-counter second instance).
module tb_riscv_retire_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic        rv;
   logic [31:0] rinst;
   logic        rwe;
   logic [4:0]  rwa;
   logic [31:0] rwd;
   logic [11:0] raddr;
   logic        rbr;

   logic [31:0] num;
   logic [31:0] outp;
   logic        halt;
   logic [3:0]  w_num;
   logic [31:0] w_outp;
   logic        w_halt;
`ifdef RETIRE_CYCLE_CNT_EN
   logic [31:0] cyc;
   logic [3:0]  w_cyc;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   riscv_retire_monitor u_dut (
      .CLK             (clk),
      .RST             (rst),
      .RETIRE_VALID    (rv),
      .RETIRE_INST     (rinst),
      .RETIRE_RF_WE    (rwe),
      .RETIRE_RF_WA    (rwa),
      .RETIRE_RF_WD    (rwd),
      .RETIRE_MEM_ADDR (raddr),
      .RETIRE_BR_TAKEN (rbr),
      .NUM_INST        (num),
      .OUTPUT_PORT     (outp),
      .HALT            (halt)
`ifdef RETIRE_CYCLE_CNT_EN
      ,
      .CYCLE_CNT       (cyc)
`endif
   );

   riscv_retire_monitor #(.CNT_WIDTH(4)) u_wrap (
      .CLK             (clk),
      .RST             (rst),
      .RETIRE_VALID    (rv),
      .RETIRE_INST     (rinst),
      .RETIRE_RF_WE    (rwe),
      .RETIRE_RF_WA    (rwa),
      .RETIRE_RF_WD    (rwd),
      .RETIRE_MEM_ADDR (raddr),
      .RETIRE_BR_TAKEN (rbr),
      .NUM_INST        (w_num),
      .OUTPUT_PORT     (w_outp),
      .HALT            (w_halt)
`ifdef RETIRE_CYCLE_CNT_EN
      ,
      .CYCLE_CNT       (w_cyc)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic retire(input logic [31:0] inst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [11:0] addr, input logic br);
      rv = 1'b1; rinst = inst; rwe = we; rwa = wa; rwd = wd; raddr = addr; rbr = br;
      @(posedge clk); #1;
      rv = 1'b0;
   endtask

   task automatic bubble();
      rv = 1'b0; rinst = $urandom; rwe = 1'b1; rwa = 5'd3; rwd = $urandom;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; rv = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rv = 1'b0; rinst = '0; rwe = 1'b0; rwa = '0; rwd = '0; raddr = '0; rbr = 1'b0;

      // reset dominates valid retires carrying random data
      for (int i = 0; i < 3; i++) begin
         rv = 1'b1; rinst = $urandom; rwe = 1'b1; rwa = 5'd7; rwd = $urandom;
         raddr = 12'($urandom); rbr = 1'b1;
         @(posedge clk); #1;
         chk("rst_num", num, 32'd0);
         chk("rst_out", outp, 32'd0);
         chk("rst_halt", {31'b0, halt}, 32'd0);
      end
      rst = 1'b0; rv = 1'b0;

      // register writeback observation
      retire(32'h02200093, 1'b1, 5'd1, 32'h22, 12'h0, 1'b0);
      chk("addi1_num", num, 32'd1);
      chk("addi1_out", outp, 32'h22);
      retire(32'h04400093, 1'b1, 5'd1, 32'h44, 12'h0, 1'b0);
      chk("addi2_num", num, 32'd2);
      chk("addi2_out", outp, 32'h44);
      bubble();
      chk("bubble_num", num, 32'd2);
      chk("bubble_out", outp, 32'h44);

      // store address, branch outcome, rd=x0 hold
      retire(32'h00102023, 1'b0, 5'd0, 32'h0, 12'hf00, 1'b0);
      chk("store_out", outp, 32'hf00);
      chk("store_num", num, 32'd3);
      retire(32'h00208063, 1'b0, 5'd0, 32'h0, 12'h123, 1'b1);
      chk("beq_out", outp, 32'h1);
      retire(32'h00000013, 1'b1, 5'd0, 32'h55, 12'h0, 1'b0);
      chk("x0_out", outp, 32'h1);
      chk("x0_num", num, 32'd5);
      retire(32'h00208063, 1'b0, 5'd0, 32'h0, 12'h0, 1'b0);
      chk("bnt_out", outp, 32'h0);

      // interrupted halt sequence does not halt
      do_reset();
      retire(32'h00c00093, 1'b1, 5'd1, 32'hc, 12'h0, 1'b0);
      retire(32'h00000013, 1'b1, 5'd0, 32'h0, 12'h0, 1'b0);
      retire(32'h00008067, 1'b0, 5'd0, 32'h0, 12'h0, 1'b0);
      chk("brk_halt", {31'b0, halt}, 32'd0);
      chk("brk_num", num, 32'd3);

      // halt sequence with bubbles in between
      do_reset();
      retire(32'h00c00093, 1'b1, 5'd1, 32'hc, 12'h0, 1'b0);
      chk("h0_out", outp, 32'hc);
      chk("h0_halt", {31'b0, halt}, 32'd0);
      bubble();
      bubble();
      chk("hb_halt", {31'b0, halt}, 32'd0);
      retire(32'h00008067, 1'b0, 5'd0, 32'h0, 12'h0, 1'b0);
      chk("h1_halt", {31'b0, halt}, 32'd1);
      chk("h1_num", num, 32'd2);
      chk("h1_out", outp, 32'hc);
      retire(32'h09900093, 1'b1, 5'd1, 32'h99, 12'h0, 1'b0);
      chk("post_num", num, 32'd2);
      chk("post_out", outp, 32'hc);
      chk("post_halt", {31'b0, halt}, 32'd1);
`ifdef RETIRE_CYCLE_CNT_EN
      chk("cyc_frozen", cyc, 32'd4);
`endif

      // reset while halted, then reset while armed
      do_reset();
      chk("rh_halt", {31'b0, halt}, 32'd0);
      chk("rh_num", num, 32'd0);
      chk("rh_out", outp, 32'd0);
      retire(32'h00c00093, 1'b1, 5'd1, 32'hc, 12'h0, 1'b0);
      chk("arm_num", num, 32'd1);
      do_reset();
      chk("ra_num", num, 32'd0);
      retire(32'h00008067, 1'b0, 5'd0, 32'h0, 12'h0, 1'b0);
      chk("ra_halt", {31'b0, halt}, 32'd0);
      chk("ra_num2", num, 32'd1);

      // counter wrap on the 4-bit instance
      do_reset();
      for (int i = 0; i < 15; i++) retire(32'h00100093, 1'b1, 5'd1, 32'(i), 12'h0, 1'b0);
      chk("wrap_max", {28'b0, w_num}, 32'd15);
      retire(32'h00100093, 1'b1, 5'd1, 32'h77, 12'h0, 1'b0);
      chk("wrap_zero", {28'b0, w_num}, 32'd0);
      chk("wide_num", num, 32'd16);
      chk("wrap_out", w_outp, 32'h77);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/riscv_retire_monitor.md
Name: riscv_retire_monitor

Overview:
- Core-side producer of the architectural observation signals NUM_INST, OUTPUT_PORT and HALT that the lab benches sample on every CLK edge.
- Sits at the writeback/retire stage of RISCV_TOP.
- Consumes one retire event per cycle and maintains:
  - a retired-instruction counter;
  - the per-instruction OUTPUT_PORT value;
  - a sticky halt detector for the two-instruction halt sequence.

Parameters:
- HALT_INST0, 32'h00c00093, first halt-sequence word (addi x1,x0,12)
- HALT_INST1, 32'h00008067, second halt-sequence word (jalr x0,0(x1))
- CNT_WIDTH, 32, width of NUM_INST (and CYCLE_CNT when enabled)

Ports:
- CLK  input  1  core clock
- RST  input  1  synchronous reset, active-high
- RETIRE_VALID  input  1  one instruction retires this cycle
- RETIRE_INST  input  32  instruction word of the retiring instruction
- RETIRE_RF_WE  input  1  retiring instruction writes the register file
- RETIRE_RF_WA  input  5  destination register
- RETIRE_RF_WD  input  32  writeback data
- RETIRE_MEM_ADDR  input  12  effective data address (valid for stores)
- RETIRE_BR_TAKEN  input  1  branch outcome (valid for B-type)
- NUM_INST  output  CNT_WIDTH  retired-instruction count
- OUTPUT_PORT  output  32  observation value of the last retired instruction
- HALT  output  1  sticky halt flag

Behaviour:
- Clocking and reset:
  - One clock (CLK); reset is synchronous and active-high (RST).
  - All state updates on posedge CLK.
  - RST dominates every other input in the same cycle.
- Reset values: NUM_INST=0, OUTPUT_PORT=0, HALT=0, FSM=IDLE.
- Latency: outputs reflect a retire one cycle after RETIRE_VALID is sampled (registered outputs only; no combinational path from inputs to outputs).
- Cycles with RETIRE_VALID=0 (bubbles) leave all state unchanged.
- NUM_INST:
  - Increments by 1 per accepted retire.
  - Wraps from all-ones to 0.
  - Both halt-sequence instructions are counted.
- OUTPUT_PORT, on an accepted retire, selected by opcode RETIRE_INST[6:0]:
  - STORE (0100011): {20'b0, RETIRE_MEM_ADDR}
  - BRANCH (1100011): {31'b0, RETIRE_BR_TAKEN}
  - else if RETIRE_RF_WE=1 and RETIRE_RF_WA!=0: RETIRE_RF_WD
  - else (rd=x0, no write): hold previous value
- Halt FSM, advanced only on accepted retires:
  - IDLE: inst==HALT_INST0 -> ARMED; else stay.
  - ARMED: inst==HALT_INST1 -> HALTED; inst==HALT_INST0 -> ARMED; other -> IDLE.
  - HALTED: absorbing. HALT=1 from the edge that enters HALTED.
- Bubbles between the two halt words do not break the sequence.
- After HALT=1, further retires are ignored: NUM_INST, OUTPUT_PORT and FSM are frozen until RST.
- The halting jalr updates NUM_INST and OUTPUT_PORT normally (rd=x0, so OUTPUT_PORT holds).
- RST asserted mid-sequence (ARMED) or while HALTED returns to reset values on that edge.

Optional Feature:
- Macro RETIRE_CYCLE_CNT_EN.
- Defined:
  - Adds output CYCLE_CNT [CNT_WIDTH-1:0], reset 0.
  - Increments every cycle while HALT=0 and freezes once HALT=1, giving the bench a core-side cycle count to compare with its own.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants OP_STORE, OP_BRANCH, OP_JALR, OP_OPIMM;
  - halt FSM state typedef {IDLE, ARMED, HALTED};
  - default halt-word constants.
- One natural sub-module: riscv_halt_detect (the FSM, outputs halted). Counter and output mux stay in the top.

Test Plan:
- RST=1 for 3 cycles with RETIRE_VALID=1 and random inputs -> NUM_INST=0, OUTPUT_PORT=0, HALT=0 throughout.
- Retire addi x1,x0,0x22 (RF_WE=1, WA=1, WD=0x22), then the same with WD=0x44 -> after edge 1 NUM_INST=1 / OUTPUT_PORT=0x22; after edge 2 NUM_INST=2 / OUTPUT_PORT=0x44.
- Store with MEM_ADDR=0xf00, then beq with BR_TAKEN=1, then an instruction with WA=0 and WE=1 -> OUTPUT_PORT sequence 0xf00, 0x1, 0x1.
- Retire 0x00c00093, two bubbles, then 0x00008067 -> HALT=1 one cycle after jalr; NUM_INST=2; a later retire leaves NUM_INST=2.
- Retire 0x00c00093, then 0x00000013, then 0x00008067 -> HALT stays 0, NUM_INST=3.
- Preload NUM_INST to 0xFFFFFFFF via 2^32-1 retires (or force), then one retire -> NUM_INST=0. Separately, RST while ARMED, then 0x00008067 -> HALT=0, NUM_INST=1.
